// File: rtl/tt_pad_ctrl_seq.sv
// Per-pad control sequencer: serial config shadow/active, break-before-make OE turnaround,
// synchronised and glitch-filtered pad input with edge pulse. Pad controls are registered (1 cycle).
module tt_pad_ctrl_seq #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TURN_CYC    = 2,
  parameter int         FILT_MAX    = 8,
  parameter logic [7:0] RST_CFG     = 8'h02
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_shift_en,
  input  logic cfg_sdi,
  output logic cfg_sdo,
  input  logic cfg_load,
  output logic busy,
  input  logic out_data,
  output logic in_data,
  output logic in_edge,
  input  logic pad_y,
  output logic pad_a,
  output logic pad_oe,
  output logic pad_ie,
  output logic pad_sl,
  output logic pad_cs,
  output logic pad_pd,
  output logic pad_pu
);

  localparam int CW = $clog2(FILT_MAX + 1);
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, OE_OFF, TURN, APPLY} state_t;

  state_t                 state, state_nxt;
  logic [TW-1:0]          cnt, cnt_nxt;
  logic [7:0]             shadow, active, pending;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          fcnt, fcnt_nxt, filt_len;
  logic                   in_data_nxt;
  logic                   accept, dir_change, drive_ok;

  assign accept     = cfg_load & (state == IDLE);
  assign dir_change = accept & (shadow[0] != active[0]);
  // OE and A drop at the very edge a direction change is accepted.
  assign drive_ok   = active[0] & (state == IDLE) & ~dir_change;
  assign busy       = (state != IDLE);
  assign cfg_sdo    = shadow[7];
  assign s          = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (dir_change) state_nxt = OE_OFF;
      OE_OFF: begin
        state_nxt = TURN;
        cnt_nxt   = TW'(TURN_CYC - 1);
      end
      TURN:   if (cnt == '0) state_nxt = APPLY;
              else cnt_nxt = cnt - TW'(1);
      APPLY:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shadow  <= '0;
      active  <= RST_CFG;
      pending <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cfg_shift_en) shadow <= {shadow[6:0], cfg_sdi};
      if (accept) pending <= shadow;
      if (accept && !dir_change) active <= shadow;
      else if (state == APPLY) active <= pending;
    end
  end

  always_comb begin
    case (active[7:6])
      2'd0:    filt_len = '0;
      2'd1:    filt_len = CW'(2);
      2'd2:    filt_len = CW'(4);
      default: filt_len = CW'(FILT_MAX);
    endcase
  end

  always_comb begin
    in_data_nxt = in_data;
    fcnt_nxt    = fcnt;
    if (!active[1]) begin
      fcnt_nxt = '0;
    end else if (filt_len == '0) begin
      in_data_nxt = s;
      fcnt_nxt    = '0;
    end else if (s == in_data) begin
      fcnt_nxt = '0;
    end else if (fcnt >= filt_len - CW'(1)) begin
      in_data_nxt = s;
      fcnt_nxt    = '0;
    end else if (fcnt != CW'(FILT_MAX)) begin
      fcnt_nxt = fcnt + CW'(1);
    end
    // A new filter length must not inherit a count from the old one.
    if (state == APPLY) fcnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fcnt    <= '0;
      in_data <= 1'b0;
      in_edge <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_y};
      fcnt    <= fcnt_nxt;
      in_data <= in_data_nxt;
      in_edge <= in_data_nxt ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_a  <= 1'b0;
      pad_oe <= 1'b0;
      pad_ie <= RST_CFG[1];
      pad_sl <= RST_CFG[2];
      pad_cs <= RST_CFG[3];
      pad_pd <= RST_CFG[4];
      pad_pu <= RST_CFG[5];
    end else begin
      pad_a  <= drive_ok & out_data;
      pad_oe <= drive_ok;
      pad_ie <= active[1];
      pad_sl <= active[2];
      pad_cs <= active[3];
      pad_pd <= active[4];
      pad_pu <= active[5];
    end
  end

endmodule
